// File: rtl/adder_pipe_pkg.sv
// Shared types and default sizes for the pipelined add/subtract stage.
package adder_pipe_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_STAGES = 2;
  localparam int unsigned DEF_TAG_W  = 4;

  // Default-sized slot; adder_pipe builds its own WIDTH/TAG_W variant of this
  // layout and hands it to adder_pipe_slot as a type parameter.
  typedef struct packed {
    logic                 vld;
    logic [DEF_WIDTH:0]   c;
    logic [DEF_TAG_W-1:0] tag;
  } slot_def_t;

endpackage

// File: rtl/adder_pipe_slot.sv
// One pipeline register slot {vld, c, tag}; payload only changes on load.
module adder_pipe_slot
  import adder_pipe_pkg::*;
#(
  parameter type slot_t = slot_def_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  logic  adv_i,
  input  slot_t d_i,
  output slot_t q_o
);

  slot_t slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (load_i) begin
      slot_d     = d_i;
      slot_d.vld = 1'b1;
    end else if (adv_i) begin
      slot_d.vld = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign q_o = slot_q;

endmodule

// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit add/subtract with valid/ready on both sides and a tag.
// Define ADDER_PIPE_SAT_EN for saturating results (c[WIDTH] becomes the flag).
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES,
  parameter int unsigned TAG_W  = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [WIDTH:0]   c,
  output logic [TAG_W-1:0] tag_out,
  output logic             busy
);

  typedef struct packed {
    logic             vld;
    logic [WIDTH:0]   c;
    logic [TAG_W-1:0] tag;
  } slot_t;

  logic [WIDTH:0]    sum, diff, result;
  slot_t             head;
  slot_t             slot_q [STAGES];
  logic [STAGES-1:0] vld, adv, load;
  logic              rdy_chain;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
`ifdef ADDER_PIPE_SAT_EN
    unique case (op_e'(op))
      OP_ADD:  result = sum[WIDTH]  ? '1 : sum;
      OP_SUB:  result = diff[WIDTH] ? {1'b1, {WIDTH{1'b0}}} : diff;
      default: result = '0;
    endcase
`else
    unique case (op_e'(op))
      OP_ADD:  result = sum;
      OP_SUB:  result = diff;
      default: result = '0;
    endcase
`endif
  end

  always_comb begin
    head     = '0;
    head.vld = 1'b1;
    head.c   = result;
    head.tag = tag_in;
  end

  // Walk from the output back to slot 0: a slot can take new data when it is
  // empty or its occupant is leaving this cycle.
  always_comb begin
    rdy_chain = ready_out;
    adv       = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      adv[STAGES-1-i] = vld[STAGES-1-i] & rdy_chain;
      rdy_chain       = ~vld[STAGES-1-i] | rdy_chain;
    end
  end

  assign ready_in = rdy_chain;

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    assign vld[k] = slot_q[k].vld;
    if (k == 0) begin : g_head
      assign load[k] = valid_in & rdy_chain;
      adder_pipe_slot #(
        .slot_t(slot_t)
      ) u_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load[k]),
        .adv_i  (adv[k]),
        .d_i    (head),
        .q_o    (slot_q[k])
      );
    end else begin : g_body
      assign load[k] = adv[k-1];
      adder_pipe_slot #(
        .slot_t(slot_t)
      ) u_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load[k]),
        .adv_i  (adv[k]),
        .d_i    (slot_q[k-1]),
        .q_o    (slot_q[k])
      );
    end
  end

  assign valid_out = slot_q[STAGES-1].vld;
  assign c         = slot_q[STAGES-1].c;
  assign tag_out   = slot_q[STAGES-1].tag;
  assign busy      = |vld;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: queue-based reference model plus directed vectors.
module tb_adder_pipe;
  import adder_pipe_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned S = 2;
  localparam int unsigned T = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid_in = 1'b0;
  logic         ready_in;
  logic         op = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [T-1:0] tag_in = '0;
  logic         valid_out;
  logic         ready_out = 1'b1;
  logic [W:0]   c;
  logic [T-1:0] tag_out;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;
  int acc_n = 0;
  int rel_n = 0;

  typedef struct {
    logic [W:0]   c;
    logic [T-1:0] tag;
  } exp_t;
  exp_t q[$];

  logic         hold_prev = 1'b0;
  logic [W:0]   c_prev = '0;
  logic [T-1:0] tag_prev = '0;

  adder_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .op        (op),
    .a         (a),
    .b         (b),
    .tag_in    (tag_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .c         (c),
    .tag_out   (tag_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference arithmetic from the plain integer definition of the result.
  function automatic logic [W:0] model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned r;
    int unsigned lim;
    lim = 1 << W;
    if (!o) begin
      r = x + y;
`ifdef ADDER_PIPE_SAT_EN
      if (r >= lim) r = 2 * lim - 1;
`endif
    end else if (x >= y) begin
      r = x - y;
    end else begin
`ifdef ADDER_PIPE_SAT_EN
      r = lim;
`else
      r = 2 * lim + x - y;
`endif
    end
    return r[W:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("stall_hold_valid", 32'(valid_out), 32'd1);
        check("stall_hold_c", 32'(c), 32'(c_prev));
        check("stall_hold_tag", 32'(tag_out), 32'(tag_prev));
      end
      check("busy_vs_model", 32'(busy), 32'(q.size() != 0));
      if (valid_out) check("no_stale_output", 32'(q.size() != 0), 32'd1);
      if (valid_out && ready_out && q.size() != 0) begin
        e = q.pop_front();
        check("result_c", 32'(c), 32'(e.c));
        check("result_tag", 32'(tag_out), 32'(e.tag));
        rel_n++;
      end
      if (valid_in && ready_in) begin
        e.c   = model(op, a, b);
        e.tag = tag_in;
        q.push_back(e);
        acc_n++;
      end
      hold_prev = valid_out && !ready_out;
      c_prev    = c;
      tag_prev  = tag_out;
    end
  end

  // Called at posedge+1 with an empty pipe; pins latency and the literal result.
  task automatic single(input logic o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [T-1:0] t, input logic [W:0] ec);
    ready_out = 1'b1;
    op = o; a = ia; b = ib; tag_in = t; valid_in = 1'b1;
    check("single_ready_in", 32'(ready_in), 32'd1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    check("single_lat1_valid", 32'(valid_out), 32'd0);
    check("single_lat1_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("single_lat2_valid", 32'(valid_out), 32'd1);
    check("single_lat2_c", 32'(c), 32'(ec));
    check("single_lat2_tag", 32'(tag_out), 32'(t));
    check("single_lat2_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("single_drain_valid", 32'(valid_out), 32'd0);
    check("single_drain_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, cyc, acc_early, acc_mid;
    logic accd;

    #12;
    check("reset_valid_out", 32'(valid_out), 32'd0);
    check("reset_c", 32'(c), 32'd0);
    check("reset_tag_out", 32'(tag_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_in_after_reset", 32'(ready_in), 32'd1);

    single(OP_ADD, 8'd200, 8'd100, 4'd3, 9'h12C);
`ifdef ADDER_PIPE_SAT_EN
    single(OP_SUB, 8'd5, 8'd7, 4'd4, 9'h100);
    single(OP_ADD, 8'd255, 8'd255, 4'd5, 9'h1FF);
`else
    single(OP_SUB, 8'd5, 8'd7, 4'd4, 9'h1FE);
    single(OP_ADD, 8'd255, 8'd255, 4'd5, 9'h1FE);
`endif
    single(OP_SUB, 8'd7, 8'd5, 4'd6, 9'h002);
    single(OP_ADD, 8'd128, 8'd127, 4'd7, 9'h0FF);

    // 16-transaction stream; ready_out low for cycles 0-4 (empty pipe fills)
    // and again for 10-14 (full pipe held mid-stream).
    idx = 0; cyc = 0; acc_early = 0; acc_mid = 0;
    while ((idx < 16 || busy) && cyc < 200) begin
      ready_out = !((cyc < 5) || (cyc >= 10 && cyc < 15));
      valid_in  = (idx < 16);
      op        = idx[0];
      a         = 8'(idx * 37);
      b         = 8'(idx * 23 + 5);
      tag_in    = 4'(idx);
      @(negedge clk);
      accd = valid_in && ready_in;
      if (cyc == 5 || cyc == 15) check("ready_in_on_release", 32'(ready_in), 32'd1);
      if (cyc == 15) check("accept_and_release", 32'({accd, valid_out && ready_out}), 32'd3);
      if (cyc < 5 && accd) acc_early++;
      if (cyc >= 10 && cyc < 15 && accd) acc_mid++;
      if (accd) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    valid_in = 1'b0;
    ready_out = 1'b1;
    check("stream_all_accepted", 32'(idx), 32'd16);
    check("fill_accepts_before_stall", 32'(acc_early), 32'd2);
    check("full_pipe_accepts_in_stall", 32'(acc_mid), 32'd0);
    check("count_in_eq_out", 32'(acc_n), 32'(rel_n));

    // Two transactions in flight, then asynchronous reset.
    ready_out = 1'b0;
    op = 1'b0; a = 8'd1; b = 8'd2; tag_in = 4'd9; valid_in = 1'b1;
    @(posedge clk); #1;
    a = 8'd3; b = 8'd4; tag_in = 4'd10;
    @(posedge clk); #1;
    valid_in = 1'b0;
    check("inflight_busy", 32'(busy), 32'd1);
    check("inflight_valid_out", 32'(valid_out), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_drop_valid_out", 32'(valid_out), 32'd0);
    check("reset_drop_busy", 32'(busy), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    ready_out = 1'b1;
    @(posedge clk); #1;
    check("post_reset_no_stale", 32'(valid_out), 32'd0);
    check("post_reset_busy", 32'(busy), 32'd0);
    single(OP_ADD, 8'd50, 8'd60, 4'd5, 9'd110);

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
